// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit
//   Debug/trace reader for the core register file. On request it halts the
//   core, then reads every architectural register through a spare read port
//   and streams the values out over valid/ready. It pulses done when the
//   last value has been accepted and holds an XOR checksum of the accepted data.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   start      one-cycle dump request, honoured only when idle
//   abort      cancels a dump in progress
//   halt_req   asks the core to stop register writes
//   halt_ack   core confirms it is halted
//   rd_addr    register file read address
//   rd_data    combinational read data for rd_addr
//   out_valid  stream beat valid
//   out_ready  consumer accepts the beat
//   out_data   register value of the current beat
//   out_index  register index of the current beat
//   out_last   current beat carries the last register index
//   busy       a dump is in progress (not idle)
//   done       one-cycle completion pulse
//   checksum   XOR of all accepted beats, held until the next start
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start
// HALT_WAIT | halt_req raised, waiting for halt_ack
// STREAM    | walking the register file and emitting beats
// DONE      | last beat accepted, done pulse, returns to IDLE next cycle
module regfile_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter bit SKIP_X0  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HALT_WAIT = 2'd1,
    S_STREAM    = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(SKIP_X0 ? 1 : 0);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                exhausted_q, exhausted_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_index_q, out_index_d;
  logic                halt_req_q, halt_req_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                load_en;
  logic                beat_acc;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    exhausted_d = exhausted_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    halt_req_d  = halt_req_q;
    checksum_d  = checksum_q;
    load_en     = 1'b0;
    beat_acc    = out_valid_q && out_ready;

    // abort beats every other transition, including a beat accepted in the
    // same cycle, so that beat never reaches the checksum
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      halt_req_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d     = S_HALT_WAIT;
            halt_req_d  = 1'b1;
            checksum_d  = '0;
            idx_d       = FIRST_IDX;
            exhausted_d = 1'b0;
          end
        end
        S_HALT_WAIT: begin
          halt_req_d = 1'b1;
          if (halt_ack) state_d = S_STREAM;
        end
        S_STREAM: begin
          // the output register refills whenever it is empty or being drained,
          // giving one beat per cycle with out_ready held high
          load_en = !exhausted_q && (!out_valid_q || out_ready);
          if (beat_acc) checksum_d = checksum_q ^ out_data_q;
          if (load_en) begin
            out_data_d  = rd_data;
            out_index_d = idx_q;
            out_valid_d = 1'b1;
            if (idx_q == LAST_IDX) exhausted_d = 1'b1;
            else                   idx_d       = idx_q + ADDR_W'(1);
          end else if (beat_acc) begin
            out_valid_d = 1'b0;
          end
          if (exhausted_q && beat_acc) begin
            state_d    = S_DONE;
            halt_req_d = 1'b0;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      exhausted_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      halt_req_q  <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      exhausted_q <= exhausted_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      halt_req_q  <= halt_req_d;
      checksum_q  <= checksum_d;
    end
  end

  assign rd_addr   = idx_q;
  assign halt_req  = halt_req_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_valid_q && (out_index_q == LAST_IDX);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
module tb_regfile_dump_unit;

  logic clk;
  logic rst_n, start, abort, halt_ack, out_ready;
  logic [31:0] regs [32];

  logic        halt_req0, out_valid0, out_last0, busy0, done0;
  logic [4:0]  rd_addr0, out_index0;
  logic [31:0] rd_data0, out_data0, checksum0;
  logic        halt_req1, out_valid1, out_last1, busy1, done1;
  logic [4:0]  rd_addr1, out_index1;
  logic [31:0] rd_data1, out_data1, checksum1;

  assign rd_data0 = regs[rd_addr0];
  assign rd_data1 = regs[rd_addr1];

  regfile_dump_unit #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .halt_req(halt_req0), .halt_ack(halt_ack), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_index(out_index0), .out_last(out_last0), .busy(busy0), .done(done0),
    .checksum(checksum0));

  regfile_dump_unit #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b1)) dut_skip (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .halt_req(halt_req1), .halt_ack(halt_ack), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_index(out_index1), .out_last(out_last1), .busy(busy1), .done(done1),
    .checksum(checksum1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: which beat must come next, what the running
  // XOR of accepted beats is, and whether a dump is in flight.
  bit          m_init = 1'b0;
  bit          m_busy [2];
  bit          m_acked [2];
  bit          m_done_due [2];
  bit          m_stall [2];
  int          m_next [2];
  int          m_nacc [2];
  logic [31:0] m_xor [2];
  logic [4:0]  m_pidx [2];
  logic [31:0] m_pdata [2];

  task automatic model_step(input int k, input logic ov, input logic [4:0] oi,
                            input logic [31:0] od, input logic ol, input logic hr,
                            input logic bz, input logic dn, input logic [31:0] cs);
    if (m_init) begin
      chk($sformatf("u%0d_busy", k), 32'(bz), 32'(m_busy[k]));
      chk($sformatf("u%0d_done", k), 32'(dn), 32'(m_done_due[k]));
      chk($sformatf("u%0d_halt_req", k), 32'(hr), 32'(m_busy[k] && !m_done_due[k]));
      chk($sformatf("u%0d_checksum", k), cs, m_xor[k]);
      chk($sformatf("u%0d_out_last", k), 32'(ol), 32'(ov && (oi == 5'd31)));
      if (!m_busy[k] || !m_acked[k])
        chk($sformatf("u%0d_valid_early", k), 32'(ov), 32'd0);
      if (ov) begin
        chk($sformatf("u%0d_index_order", k), 32'(oi), 32'(m_next[k]));
        chk($sformatf("u%0d_data", k), od, regs[oi]);
      end
      if (m_stall[k]) begin
        chk($sformatf("u%0d_stall_valid", k), 32'(ov), 32'd1);
        chk($sformatf("u%0d_stall_index", k), 32'(oi), 32'(m_pidx[k]));
        chk($sformatf("u%0d_stall_data", k), od, m_pdata[k]);
      end
    end
    if (!rst_n) begin
      m_busy[k] = 0; m_acked[k] = 0; m_done_due[k] = 0; m_stall[k] = 0;
      m_xor[k] = '0; m_next[k] = 0;
    end else if (m_init) begin
      m_stall[k] = 0;
      if (m_busy[k] && abort) begin
        m_busy[k] = 0; m_acked[k] = 0; m_done_due[k] = 0;
      end else if (m_done_due[k]) begin
        m_busy[k] = 0; m_acked[k] = 0; m_done_due[k] = 0;
      end else if (!m_busy[k]) begin
        if (start) begin
          m_busy[k] = 1; m_acked[k] = 0; m_xor[k] = '0;
          m_next[k] = (k == 0) ? 0 : 1; m_nacc[k] = 0;
        end
      end else begin
        if (halt_ack) m_acked[k] = 1;
        if (ov && out_ready) begin
          m_xor[k] = m_xor[k] ^ od;
          m_next[k]++;
          m_nacc[k]++;
          if (m_next[k] == 32) m_done_due[k] = 1;
        end else if (ov) begin
          m_stall[k] = 1; m_pidx[k] = oi; m_pdata[k] = od;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, out_valid0, out_index0, out_data0, out_last0, halt_req0, busy0, done0, checksum0);
    model_step(1, out_valid1, out_index1, out_data1, out_last1, halt_req1, busy1, done1, checksum1);
    if (!rst_n) m_init = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_pattern(input int p);
    for (int i = 0; i < 32; i++)
      regs[i] = (p == 1) ? 32'(i) * 32'h0101_0101 : (32'h1 << i);
  endtask

  task automatic run_until_done(input int budget, input string tag, output int took);
    int n;
    n = 0;
    while (!done0 && n < budget) begin
      tick();
      n++;
    end
    took = n;
    if (!done0) chk({tag, "_timeout"}, 32'(n), 32'(-1));
  endtask

  task automatic wait_index(input logic [4:0] want, input int budget, input string tag);
    int n;
    n = 0;
    while (!(out_valid0 && out_index0 == want) && n < budget) begin
      tick();
      n++;
    end
    if (!(out_valid0 && out_index0 == want)) chk({tag, "_timeout"}, 32'(n), 32'(-1));
  endtask

  initial begin
    int c0, rel, took;
    int first_halt, first_valid, last_valid, done_cyc, idle_cyc, nlast;
    int sk_done;
    logic [4:0]  last_idx, sk_first_idx;
    logic [31:0] data_at4, data_at34;

    rst_n = 0; start = 0; abort = 0; halt_ack = 0; out_ready = 0;
    load_pattern(1);
    repeat (2) tick();
    rst_n = 1;

    // reset values
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_halt_req", 32'(halt_req0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_checksum", checksum0, 32'd0);
    chk("rst_rd_addr", 32'(rd_addr0), 32'd0);
    chk("rst_out_data", out_data0, 32'd0);
    chk("rst_out_index", 32'(out_index0), 32'd0);
    tick();

    // full dump, no backpressure, latency pinned
    halt_ack = 1; out_ready = 1;
    start = 1; c0 = cyc;
    first_halt = -1; first_valid = -1; last_valid = -1; done_cyc = -1; idle_cyc = -1;
    nlast = 0; last_idx = '0; sk_first_idx = '0; sk_done = -1;
    data_at4 = '0; data_at34 = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      start = 0;
      rel = cyc - c0;
      if (halt_req0 && first_halt < 0) first_halt = rel;
      if (out_valid0) begin
        if (first_valid < 0) first_valid = rel;
        last_valid = rel;
      end
      if (rel == 4) data_at4 = out_data0;
      if (rel == 34) data_at34 = out_data0;
      if (out_last0) begin nlast++; last_idx = out_index0; end
      if (done0 && done_cyc < 0) done_cyc = rel;
      if (done_cyc >= 0 && !busy0 && idle_cyc < 0) idle_cyc = rel;
      if (out_valid1 && rel == 3) sk_first_idx = out_index1;
      if (done1 && sk_done < 0) sk_done = rel;
    end
    chk("lat_halt_req", 32'(first_halt), 32'd1);
    chk("lat_first_valid", 32'(first_valid), 32'd3);
    chk("lat_last_valid", 32'(last_valid), 32'd34);
    chk("lat_done", 32'(done_cyc), 32'd35);
    chk("lat_idle", 32'(idle_cyc), 32'd36);
    chk("data_beat1", data_at4, 32'h0101_0101);
    chk("data_beat31", data_at34, 32'h1F1F_1F1F);
    chk("last_count", 32'(nlast), 32'd1);
    chk("last_index", 32'(last_idx), 32'd31);
    chk("beats_full", 32'(m_nacc[0]), 32'd32);
    chk("checksum_full", checksum0, 32'h0);
    chk("skip_first_index", 32'(sk_first_idx), 32'd1);
    chk("skip_beats", 32'(m_nacc[1]), 32'd31);
    chk("skip_done", 32'(sk_done), 32'd34);
    chk("skip_checksum", checksum1, 32'h0);

    // backpressure 1,0,0,1 with one-hot register contents
    load_pattern(2);
    start = 1; c0 = cyc;
    took = 0;
    for (int i = 0; i < 300 && !(done0 && i > 0); i++) begin
      tick();
      start = 0;
      rel = cyc - c0;
      out_ready = (rel % 4 == 0) || (rel % 4 == 3);
    end
    if (!done0) chk("bp_timeout", 32'(cyc - c0), 32'(-1));
    out_ready = 1;
    tick();
    chk("bp_beats", 32'(m_nacc[0]), 32'd32);
    chk("bp_checksum", checksum0, 32'hFFFF_FFFF);
    chk("bp_skip_beats", 32'(m_nacc[1]), 32'd31);
    chk("bp_skip_checksum", checksum1, 32'hFFFF_FFFE);
    tick();

    // halt_ack held low for 10 cycles
    load_pattern(1);
    halt_ack = 0;
    start = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      start = 0;
      chk($sformatf("hw_halt_req_c%0d", i), 32'(halt_req0), 32'd1);
      chk($sformatf("hw_valid_c%0d", i), 32'(out_valid0), 32'd0);
    end
    halt_ack = 1;
    tick();
    chk("hw_valid_stream_entry", 32'(out_valid0), 32'd0);
    tick();
    chk("hw_first_valid", 32'(out_valid0), 32'd1);
    chk("hw_first_index", 32'(out_index0), 32'd0);
    run_until_done(100, "hw", took);
    tick();
    tick();

    // abort while index 7 is offered
    start = 1;
    tick();
    start = 0;
    wait_index(5'd7, 100, "ab_wait");
    abort = 1;
    tick();
    abort = 0;
    chk("ab_valid", 32'(out_valid0), 32'd0);
    chk("ab_halt_req", 32'(halt_req0), 32'd0);
    chk("ab_busy", 32'(busy0), 32'd0);
    chk("ab_done", 32'(done0), 32'd0);
    chk("ab_partial_checksum", checksum0, 32'h0707_0707);
    repeat (3) tick();
    start = 1;
    tick();
    start = 0;
    took = 0;
    while (!out_valid0 && took < 20) begin tick(); took++; end
    chk("ab_restart_index", 32'(out_index0), 32'd0);
    chk("ab_restart_checksum", checksum0, 32'd0);
    run_until_done(100, "ab", took);
    chk("ab_restart_beats", 32'(m_nacc[0]), 32'd32);
    tick();
    tick();

    // synchronous reset mid-stream with start in the same cycle
    start = 1;
    tick();
    start = 0;
    wait_index(5'd10, 100, "rs_wait");
    rst_n = 0; start = 1;
    tick();
    rst_n = 1; start = 0;
    chk("rs_valid", 32'(out_valid0), 32'd0);
    chk("rs_halt_req", 32'(halt_req0), 32'd0);
    chk("rs_busy", 32'(busy0), 32'd0);
    chk("rs_done", 32'(done0), 32'd0);
    chk("rs_checksum", checksum0, 32'd0);
    chk("rs_out_data", out_data0, 32'd0);
    chk("rs_out_index", 32'(out_index0), 32'd0);
    chk("rs_rd_addr", 32'(rd_addr0), 32'd0);
    repeat (3) tick();
    chk("rs_start_ignored", 32'(busy0), 32'd0);

    // second start while busy must not restart the walk
    start = 1; c0 = cyc;
    tick();
    start = 0;
    repeat (5) tick();
    start = 1;
    tick();
    start = 0;
    run_until_done(100, "rs2", took);
    chk("rs2_done_cycle", 32'(cyc - c0), 32'd35);
    chk("rs2_beats", 32'(m_nacc[0]), 32'd32);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump_unit.md
Name: regfile_dump_unit

Overview:
- Debug/trace reader for the core's 32x32 register file. On request, halts the core and walks every architectural register through a spare read port.
- Streams each value out over a valid/ready interface, then reports completion with an XOR checksum.
- Sits beside the register file. It drives one read-address port and consumes that port's combinational read data.

Parameters:
- NUM_REGS, 32, number of registers walked; last index is NUM_REGS-1.
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.
- SKIP_X0, 0, if 1 the walk starts at index 1 and x0 is never emitted.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle dump request; honoured only in IDLE.
- abort  in  1  cancels a dump in progress.
- halt_req  out  1  asks the core to stop issuing register writes.
- halt_ack  in  1  core confirms it is halted.
- rd_addr  out  ADDR_W  read address to the register file.
- rd_data  in  DATA_W  combinational read data for rd_addr.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DATA_W  register value for the current beat.
- out_index  out  ADDR_W  register index for the current beat.
- out_last  out  1  out_valid && out_index==NUM_REGS-1.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse; high while in DONE.
- checksum  out  DATA_W  XOR of all accepted out_data; held after DONE.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; idx, exhausted, out_valid, out_data, out_index, halt_req, checksum all 0. rd_addr then follows idx = 0. Reset mid-dump is identical: no done pulse and no partial state survives.
- FSM states: IDLE, HALT_WAIT, STREAM, DONE.
- IDLE:
  - start=1 -> HALT_WAIT; checksum<=0; idx<=SKIP_X0?1:0; exhausted<=0.
  - start in any other state is ignored.
- HALT_WAIT:
  - halt_req=1.
  - halt_ack=1 -> STREAM.
  - No timeout; waits indefinitely.
- STREAM:
  - halt_req stays 1; rd_addr=idx (registered).
  - load_en = !exhausted && (!out_valid || out_ready).
  - If load_en: out_data<=rd_data, out_index<=idx, out_valid<=1. If idx==NUM_REGS-1, exhausted<=1; else idx<=idx+1.
  - Else if out_valid && out_ready: out_valid<=0.
  - Accepted beat (out_valid && out_ready): checksum<=checksum^out_data. The beat being replaced is counted; the same-cycle load does not double-count.
  - Throughput: 1 beat/cycle with out_ready held high.
  - out_data/out_index stay stable while out_valid && !out_ready.
  - Exit: exhausted && out_valid && out_ready -> DONE; out_valid<=0.
- DONE: done=1, halt_req=0; -> IDLE next cycle. checksum is held until the next start.
- Abort: abort=1 in HALT_WAIT, STREAM or DONE -> IDLE next edge; out_valid<=0, halt_req<=0, no done pulse. checksum keeps its partial value. abort in IDLE has no effect. abort wins over every other transition in the same cycle.
- halt_ack dropping during STREAM is ignored; halt is a protocol obligation of the core.
- Latency with halt_ack and out_ready tied high:
  - start at cycle 0.
  - halt_req=1 from cycle 1.
  - STREAM from cycle 2.
  - First out_valid at cycle 3.
  - Beats at cycles 3..34 (SKIP_X0=0).
  - done at cycle 35.
  - busy=0 from cycle 36.

Test Plan:
- Registers preloaded with x[i]=i*0x01010101; start; halt_ack and out_ready high -> 32 beats on cycles 3..34 with out_index 0..31 and data 0, 0x01010101 .. 0x1F1F1F1F. out_last only on index 31. done at cycle 35. checksum = XOR of all 32 values.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly -> no index lost or duplicated; out_data/out_index constant while stalled; full order 0..31 preserved.
- SKIP_X0=1 -> exactly 31 beats, indices 1..31, first out_index=1; checksum excludes x0.
- halt_ack held low 10 cycles after start -> halt_req=1 and out_valid=0 throughout. Streaming begins the cycle after halt_ack rises.
- abort when out_index=7 is valid -> next cycle out_valid=0, halt_req=0, busy=0, no done pulse. A new start then restarts from index 0 with checksum cleared.
- rst_n low for 1 cycle mid-stream -> all outputs 0 next cycle. start re-asserted in the same cycle as the reset is ignored. A second start while busy produces no restart.
